// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Write side of the instruction memory. It takes a stream of
//               program bytes, packs them little-endian into words and
//               writes the words to the text RAM starting at address 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int N = 32,
   parameter int R = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [R:0]   word_count,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   output logic         byte_ready,
   output logic         mem_we,
   output logic [R-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   output logic         busy,
   output logic         done,
   output logic         cpu_hold
);

   localparam int B  = N / 8;
   localparam int IW = (B > 1) ? $clog2(B) : 1;
   localparam int RW = R + 1;

   localparam logic [R:0]    c_depth = {1'b1, {R{1'b0}}};
   localparam logic [IW-1:0] c_last  = IW'(B - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t          r_state;
   logic [R:0]      r_remain;
   logic [R-1:0]    r_addr;
   logic [IW-1:0]   r_idx;
   logic [N-1:0]    r_asm;

   logic            w_hs;
   logic [R:0]      w_count;
   logic [N-1:0]    w_asm_next;

   always_comb begin
      w_asm_next = r_asm;
      w_asm_next[8*r_idx +: 8] = byte_data;
   end

   // Saturate so the address counter can never wrap onto address 0.
   assign w_count  = (word_count > c_depth) ? c_depth : word_count;
   assign w_hs     = (r_state == S_COLLECT) && byte_valid && byte_ready;
   assign cpu_hold = busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_remain   <= '0;
         r_addr     <= '0;
         r_idx      <= '0;
         r_asm      <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_addr   <= '0;
                  r_idx    <= '0;
                  r_remain <= w_count;
                  if (w_count == '0) begin
                     r_state <= S_DONE;
                     done    <= 1'b1;
                  end else begin
                     r_state    <= S_COLLECT;
                     done       <= 1'b0;
                     busy       <= 1'b1;
                     byte_ready <= 1'b1;
                  end
               end
            end
            S_COLLECT: begin
               if (w_hs) begin
                  r_asm <= w_asm_next;
                  if (r_idx == c_last) begin
                     r_idx      <= '0;
                     r_state    <= S_WRITE;
                     byte_ready <= 1'b0;
                     mem_we     <= 1'b1;
                     mem_addr   <= r_addr;
                     mem_wdata  <= w_asm_next;
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end
            end
            S_WRITE: begin
               r_addr   <= r_addr + R'(1);
               r_remain <= r_remain - RW'(1);
               if (r_remain == RW'(1)) begin
                  r_state <= S_DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_state    <= S_COLLECT;
                  byte_ready <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader (table + random loads).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   localparam int N = 32;
   localparam int R = 6;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [R:0]   word_count;
   logic         byte_valid;
   logic [7:0]   byte_data;
   logic         byte_ready;
   logic         mem_we;
   logic [R-1:0] mem_addr;
   logic [N-1:0] mem_wdata;
   logic         busy;
   logic         done;
   logic         cpu_hold;

   imem_loader #(.N(N), .R(R)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .cpu_hold   (cpu_hold)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t got[$];

   always @(negedge clk) begin
      if (mem_we) got.push_back('{addr: 32'(mem_addr), data: mem_wdata});
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called just after a negedge; returns on the negedge after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         chk("byte_timeout", 64'(t), 64'd0);
      end else begin
         @(negedge clk);
      end
      byte_valid = 1'b0;
   endtask

   // Reference: word k is bytes 4k..4k+3, LSB first, written to address k.
   task automatic score(input string tag, input logic [7:0] q[$], input int exp_writes);
      chk({tag, "_write_count"}, 64'(got.size()), 64'(exp_writes));
      for (int k = 0; k < exp_writes && k < got.size(); k++) begin
         chk({tag, "_addr"}, 64'(got[k].addr), 64'(k));
         chk({tag, "_data"}, 64'(got[k].data),
             64'({q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]}));
      end
   endtask

   task automatic run_load(input logic [R:0] wc, input int gap,
                           input logic [7:0] q[$], input int exp_writes);
      got.delete();
      start      = 1'b1;
      word_count = wc;
      @(negedge clk);
      start = 1'b0;
      if (exp_writes == 0) begin
         chk("zero_done", 64'(done), 64'd1);
         chk("zero_busy", 64'(busy), 64'd0);
         idle(3);
         chk("zero_busy_later", 64'(busy), 64'd0);
         chk("zero_no_write", 64'(got.size()), 64'd0);
         return;
      end
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_done_clear", 64'(done), 64'd0);
      for (int i = 0; i < 4*exp_writes; i++) begin
         send_byte(q[i]);
         if (i % 4 == 3) begin
            chk("we_latency", 64'(mem_we), 64'd1);
            chk("hold_in_load", 64'(cpu_hold), 64'd1);
         end
         if (gap > 0 && i < 4*exp_writes - 1) idle(gap);
      end
      idle(1);
      chk("end_done", 64'(done), 64'd1);
      chk("end_busy", 64'(busy), 64'd0);
      chk("end_hold", 64'(cpu_hold), 64'd0);
      if (q.size() > 4*exp_writes) begin
         byte_valid = 1'b1;
         byte_data  = q[4*exp_writes];
         for (int c = 0; c < 8; c++) begin
            chk("no_accept_after_done", 64'(byte_ready), 64'd0);
            @(negedge clk);
         end
         byte_valid = 1'b0;
      end
      score("load", q, exp_writes);
   endtask

   typedef struct {
      logic [R:0] wc;
      int         gap;
      int         nbytes;
      bit         fixed;
      int         exp_writes;
   } vec_t;

   vec_t        vecs[8];
   logic [7:0]  fixed_q[$];
   logic [7:0]  q[$];

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = '0;
      fixed_q    = {8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h50, 8'h00};

      vecs[0] = '{wc: 7'd2,   gap: 0, nbytes: 8,   fixed: 1'b1, exp_writes: 2};
      vecs[1] = '{wc: 7'd2,   gap: 3, nbytes: 8,   fixed: 1'b1, exp_writes: 2};
      vecs[2] = '{wc: 7'd0,   gap: 0, nbytes: 0,   fixed: 1'b0, exp_writes: 0};
      vecs[3] = '{wc: 7'd100, gap: 0, nbytes: 256, fixed: 1'b0, exp_writes: 64};
      vecs[4] = '{wc: 7'd1,   gap: 1, nbytes: 4,   fixed: 1'b0, exp_writes: 1};
      vecs[5] = '{wc: 7'd3,   gap: 2, nbytes: 12,  fixed: 1'b0, exp_writes: 3};
      vecs[6] = '{wc: 7'd64,  gap: 0, nbytes: 260, fixed: 1'b0, exp_writes: 64};
      vecs[7] = '{wc: 7'd127, gap: 1, nbytes: 260, fixed: 1'b0, exp_writes: 64};

      #23;
      chk("rst_byte_ready", 64'(byte_ready), 64'd0);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_cpu_hold", 64'(cpu_hold), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(1);

      // Bytes offered in IDLE are refused.
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      idle(2);
      chk("idle_no_ready", 64'(byte_ready), 64'd0);
      byte_valid = 1'b0;

      for (int i = 0; i < 8; i++) begin
         q.delete();
         if (vecs[i].fixed) q = fixed_q;
         else for (int j = 0; j < vecs[i].nbytes; j++) q.push_back(8'($urandom));
         run_load(vecs[i].wc, vecs[i].gap, q, vecs[i].exp_writes);
         if (i == 0 && got.size() == 2) begin
            chk("known_word0", 64'(got[0].data), 64'h00A00513);
            chk("known_word1", 64'(got[1].data), 64'h00500593);
         end
      end

      // Asynchronous reset in the middle of word 2 of a 3-word load.
      got.delete();
      start = 1'b1; word_count = 7'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 10; i++) send_byte(8'(8'h11 * (i + 1)));
      #2 reset = 1'b1;
      #1;
      chk("arst_byte_ready", 64'(byte_ready), 64'd0);
      chk("arst_mem_we", 64'(mem_we), 64'd0);
      chk("arst_mem_addr", 64'(mem_addr), 64'd0);
      chk("arst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_done", 64'(done), 64'd0);
      chk("arst_cpu_hold", 64'(cpu_hold), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(1);
      q = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_load(7'd1, 0, q, 1);
      if (got.size() == 1) chk("deadbeef", 64'(got[0].data), 64'hDEADBEEF);

      // start pulsed while collecting must be ignored.
      got.delete();
      q.delete();
      for (int j = 0; j < 8; j++) q.push_back(8'($urandom));
      start = 1'b1; word_count = 7'd2;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 3; i++) send_byte(q[i]);
      start = 1'b1; word_count = 7'd7;
      @(negedge clk);
      start = 1'b0;
      for (int i = 3; i < 8; i++) send_byte(q[i]);
      idle(1);
      chk("ign_start_done", 64'(done), 64'd1);
      score("ign_start", q, 2);

      // Restart from DONE with random loads.
      for (int it = 0; it < 6; it++) begin
         int wc;
         int nw;
         int extra;
         wc    = $urandom_range(0, 9);
         nw    = (wc > 64) ? 64 : wc;
         extra = $urandom_range(0, 4);
         q.delete();
         for (int j = 0; j < 4*nw + extra; j++) q.push_back(8'($urandom));
         run_load(7'(wc), $urandom_range(0, 3), q, nw);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
